// File: rtl/ps2_mouse_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits LSB first,
// odd parity, stop, then ACK check. Lines are driven as open-drain pull-low enables.
module ps2_mouse_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_DATA = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_shreg;
  logic          r_parity;
  logic [3:0]    r_bit_cnt;
  logic [CW-1:0] r_cnt;
  logic          r_busy, r_done, r_error, r_clk_dl, r_data_dl;
  logic          r_clk_meta, r_clk_s, r_clk_prev, r_data_meta, r_data_s;
  logic          w_fall, w_watch, w_timeout;

  // Synchronizers reset to the idle-high level so reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_meta  <= 1'b1;
      r_clk_s     <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_s    <= 1'b1;
    end else begin
      r_clk_meta  <= ps2_clk;
      r_clk_s     <= r_clk_meta;
      r_clk_prev  <= r_clk_s;
      r_data_meta <= ps2_data;
      r_data_s    <= r_data_meta;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_s;
  assign w_watch   = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  assign w_timeout = w_watch && !w_fall && (r_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_parity  <= 1'b0;
      r_bit_cnt <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_clk_dl  <= 1'b0;
      r_data_dl <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (w_timeout) begin
        r_clk_dl  <= 1'b0;
        r_data_dl <= 1'b0;
        r_error   <= 1'b1;
        r_busy    <= 1'b0;
        r_state   <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            // A start landing on the completion pulse is dropped; the next cycle may accept.
            if (tx_start && !r_done && !r_error) begin
              r_shreg   <= tx_data;
              r_parity  <= ~^tx_data;
              r_bit_cnt <= '0;
              r_cnt     <= '0;
              r_busy    <= 1'b1;
              r_clk_dl  <= 1'b1;
              r_data_dl <= (INHIBIT_CYCLES == 1);
              r_state   <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == INH_DATA) r_data_dl <= 1'b1;
            if (r_cnt == INH_LAST) begin
              r_clk_dl  <= 1'b0;
              r_data_dl <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_SEND;
            end
          end
          S_SEND: begin
            r_cnt <= w_fall ? '0 : r_cnt + 1'b1;
            if (w_fall) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt < 4'd8) begin
                r_data_dl <= ~r_shreg[0];
                r_shreg   <= {1'b0, r_shreg[7:1]};
              end else if (r_bit_cnt == 4'd8) begin
                r_data_dl <= ~r_parity;
              end else begin
                r_data_dl <= 1'b0;
                r_state   <= S_ACK;
              end
            end
          end
          S_ACK: begin
            r_cnt <= w_fall ? '0 : r_cnt + 1'b1;
            if (w_fall) begin
              if (!r_data_s) begin
                r_state <= S_WAIT_IDLE;
              end else begin
                r_error <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
          S_WAIT_IDLE: begin
            r_cnt <= w_fall ? '0 : r_cnt + 1'b1;
            if (r_clk_s && r_data_s) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_busy            = r_busy;
  assign tx_done            = r_done;
  assign tx_error           = r_error;
  assign ps2_clk_drive_low  = r_clk_dl;
  assign ps2_data_drive_low = r_data_dl;

endmodule
